decode_group: RTL and testbench
===============================

Name: decode_group

Overview:
- Registered, N-lane RV32IM decode stage between fetch and rename/dispatch in the superscalar core.
- Each cycle it accepts one fetch group of up to LANES instructions. For every lane it produces ALU op, operand-mux selects, memory/branch/writeback controls, map enable, dispatch class and an illegal-instruction flag.
- A 2-entry skid buffer decouples fetch from rename backpressure, and a flush input squashes the whole stage.

Parameters:
- LANES, 2, instructions per group (1..4).
- XLEN, 32, PC width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  squash all buffered groups (redirect/mispredict).
- in_valid  in  1  fetch group valid.
- in_ready  out  1  stage can accept a group this cycle.
- in_lane_valid  in  LANES  per-lane valid within group.
- in_inst  in  32*LANES  instructions; lane k = bits [32k+31:32k].
- in_pc  in  XLEN*LANES  PCs, same packing.
- out_valid  out  1  decoded group valid.
- out_ready  in  1  rename accepts group.
- out_lane_valid  out  LANES  per-lane valid (passes through).
- out_pc  out  XLEN*LANES  PCs.
- out_aluop  out  5*LANES  ALU op.
- out_aluin1_mux  out  2*LANES  00 rs1, 01 pc, 10 zero.
- out_aluin2_mux  out  2*LANES  00 rs2, 01 shamt, 10 imm12, 11 imm20.
- out_dispatch  out  2*LANES  11 simple/complex, 01 complex only, 10 FP only, 00 none.
- out_map_en, out_regwrite, out_memread, out_memwrite, out_memtoreg, out_branch  out  LANES each  per-lane controls.
- out_illegal  out  LANES  lane holds an undecodable instruction.

Behaviour:
- Reset (async): both buffer entries invalid. out_valid=0, in_ready=1. All out_* payload fields are 0.
- Latency: decode is combinational on input. The result is registered, so a group accepted at edge n appears with out_valid=1 after edge n.
- Handshake: input transfers when in_valid&in_ready. Output transfers when out_valid&out_ready. Payload is held stable while out_valid&!out_ready.
- Skid buffer: states EMPTY, ONE (main valid), TWO (main+skid valid).
  - EMPTY + accept -> ONE.
  - ONE + accept, no drain -> TWO. ONE + drain, no accept -> EMPTY. ONE + both -> ONE.
  - TWO + drain -> ONE (skid moves into main).
  - in_ready = (state!=TWO), registered, with no combinational path from out_ready.
- Flush: next state EMPTY and in_ready=1, with priority over any simultaneous accept or drain. A group presented in the flush cycle is dropped.
- Inactive lanes (in_lane_valid=0) decode to all-zero controls with out_illegal=0.
- Decode per lane, on opcode/funct3/funct7:
  - 0110011 with funct7 0000000: ADD 00000, SLL 00010, SLT 01000, SLTU 01001, XOR 00011, SRL 00101, OR 00110, AND 00111.
  - 0110011 with funct7 0100000: SUB 00001 (f3 000), SRA 00100 (f3 101); other f3 illegal.
  - 0110011 with funct7 0000001 (M): MUL 10110, MULH 10010, MULHSU 10001, MULHU 10000, DIV 11000, DIVU 11010, REM 11100, REMU 11110. Dispatch 01.
  - R-type, all variants: mux1 00, mux2 00, regwrite=1, map_en=1. Dispatch 11 unless M.
  - 0010011: same aluop per f3. mux2 10, except SLLI/SRLI/SRAI which use mux2 01.
    - SLLI needs funct7 0000000. f3 101 needs funct7 0000000 (SRLI 00101) or 0100000 (SRAI 00100).
    - regwrite=1, map_en=1, dispatch 11.
  - 0110111 LUI: aluop 00000, mux1 10, mux2 11. 0010111 AUIPC: mux1 01, mux2 11. Both regwrite=1, map_en=1, dispatch 11.
  - 0000011 load (f3 000,001,010,100,101): aluop 00000, mux2 10, memread=1, memtoreg=1, regwrite=1, map_en=1, dispatch 01.
  - 0100011 store (f3 000..010): aluop 00000, mux2 10, memwrite=1, regwrite=0, map_en=0, dispatch 01.
  - 1100011 branch (f3 not 010/011): aluop 00001, mux2 00, branch=1, regwrite=0, map_en=0, dispatch 11.
  - Any other encoding: out_illegal=1 and all controls 0. The lane stays valid so the ROB can raise the exception.
- rd=x0 does not alter map_en or regwrite; rename handles x0.

Decomposition:
- decode_pkg holds:
  - opcode constants;
  - ALUOP_* codes;
  - AIN1_*/AIN2_* mux selects;
  - DISP_* classes;
  - a packed per-lane control struct.
- Sub-module decode_lane: purely combinational single-instruction decoder, instantiated LANES times via generate.
- decode_group contains only the skid buffer FSM and the registers.

Test Plan:
- Reset then 0x002081B3 (add), 0x402081B3 (sub) in lanes 0/1 -> next cycle aluop 00000/00001, mux 00/00, regwrite=1, dispatch 11, illegal=0.
- 0x022081B3 (mul), 0x4030D093 (srai x1,x1,3) -> aluop 10110 with dispatch 01; aluop 00100 with mux2 01 and dispatch 11.
- 0xFFFFFFFF in lane 1, lane 0 = 0x0000A183 (lw) -> lane 1 illegal=1 with all controls 0; lane 0 memread=memtoreg=regwrite=1, mux2 10.
- in_valid held high for 5 groups, out_ready=0 for cycles 1-3 -> in_ready falls after 2 accepts; every group emerges once, in order, with no duplication.
- State TWO with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1; the flushed and presented groups never appear.
- rst asserted mid-stream between edges -> out_valid=0 immediately, with no clock needed.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared encodings for the RV32IM decode stage: opcodes, ALU op codes,
// operand-mux selects, dispatch classes and the per-lane control bundle.
package decode_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [4:0] ALUOP_ADD    = 5'b00000;
  localparam logic [4:0] ALUOP_SUB    = 5'b00001;
  localparam logic [4:0] ALUOP_SLL    = 5'b00010;
  localparam logic [4:0] ALUOP_XOR    = 5'b00011;
  localparam logic [4:0] ALUOP_SRA    = 5'b00100;
  localparam logic [4:0] ALUOP_SRL    = 5'b00101;
  localparam logic [4:0] ALUOP_OR     = 5'b00110;
  localparam logic [4:0] ALUOP_AND    = 5'b00111;
  localparam logic [4:0] ALUOP_SLT    = 5'b01000;
  localparam logic [4:0] ALUOP_SLTU   = 5'b01001;
  localparam logic [4:0] ALUOP_MULHU  = 5'b10000;
  localparam logic [4:0] ALUOP_MULHSU = 5'b10001;
  localparam logic [4:0] ALUOP_MULH   = 5'b10010;
  localparam logic [4:0] ALUOP_MUL    = 5'b10110;
  localparam logic [4:0] ALUOP_DIV    = 5'b11000;
  localparam logic [4:0] ALUOP_DIVU   = 5'b11010;
  localparam logic [4:0] ALUOP_REM    = 5'b11100;
  localparam logic [4:0] ALUOP_REMU   = 5'b11110;

  localparam logic [1:0] AIN1_RS1   = 2'b00;
  localparam logic [1:0] AIN1_PC    = 2'b01;
  localparam logic [1:0] AIN1_ZERO  = 2'b10;
  localparam logic [1:0] AIN2_RS2   = 2'b00;
  localparam logic [1:0] AIN2_SHAMT = 2'b01;
  localparam logic [1:0] AIN2_IMM12 = 2'b10;
  localparam logic [1:0] AIN2_IMM20 = 2'b11;

  localparam logic [1:0] DISP_NONE    = 2'b00;
  localparam logic [1:0] DISP_COMPLEX = 2'b01;
  localparam logic [1:0] DISP_FP      = 2'b10;
  localparam logic [1:0] DISP_ANY     = 2'b11;

  typedef struct packed {
    logic [4:0] aluop;
    logic [1:0] ain1;
    logic [1:0] ain2;
    logic [1:0] disp;
    logic       map_en;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       branch;
    logic       illegal;
  } lane_ctrl_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} skid_state_t;

  function automatic logic [4:0] base_aluop(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALUOP_ADD;
      3'd1:    return ALUOP_SLL;
      3'd2:    return ALUOP_SLT;
      3'd3:    return ALUOP_SLTU;
      3'd4:    return ALUOP_XOR;
      3'd5:    return ALUOP_SRL;
      3'd6:    return ALUOP_OR;
      default: return ALUOP_AND;
    endcase
  endfunction

  function automatic logic [4:0] mul_aluop(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALUOP_MUL;
      3'd1:    return ALUOP_MULH;
      3'd2:    return ALUOP_MULHSU;
      3'd3:    return ALUOP_MULHU;
      3'd4:    return ALUOP_DIV;
      3'd5:    return ALUOP_DIVU;
      3'd6:    return ALUOP_REM;
      default: return ALUOP_REMU;
    endcase
  endfunction

endpackage

// File: rtl/decode_group_if.sv
// Fetch-side and rename-side handshake bundle of the decode stage.
interface decode_group_if #(
  parameter int LANES = 2,
  parameter int XLEN  = 32
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES-1:0]      in_lane_valid;
  logic [32*LANES-1:0]   in_inst;
  logic [XLEN*LANES-1:0] in_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES-1:0]      out_lane_valid;
  logic [XLEN*LANES-1:0] out_pc;
  logic [5*LANES-1:0]    out_aluop;
  logic [2*LANES-1:0]    out_aluin1_mux;
  logic [2*LANES-1:0]    out_aluin2_mux;
  logic [2*LANES-1:0]    out_dispatch;
  logic [LANES-1:0]      out_map_en;
  logic [LANES-1:0]      out_regwrite;
  logic [LANES-1:0]      out_memread;
  logic [LANES-1:0]      out_memwrite;
  logic [LANES-1:0]      out_memtoreg;
  logic [LANES-1:0]      out_branch;
  logic [LANES-1:0]      out_illegal;

  modport master (
    output flush, in_valid, in_lane_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_lane_valid, out_pc, out_aluop, out_aluin1_mux,
           out_aluin2_mux, out_dispatch, out_map_en, out_regwrite, out_memread,
           out_memwrite, out_memtoreg, out_branch, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_lane_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_lane_valid, out_pc, out_aluop, out_aluin1_mux,
           out_aluin2_mux, out_dispatch, out_map_en, out_regwrite, out_memread,
           out_memwrite, out_memtoreg, out_branch, out_illegal
  );
endinterface

// File: rtl/decode_lane.sv
// Combinational single-instruction RV32IM decoder producing one lane's controls.
module decode_lane
  import decode_pkg::*;
(
  input  logic        lane_valid,
  input  logic [31:0] inst,
  output lane_ctrl_t  ctrl
);
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;
  logic       unused_fields;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  // Register indices and immediates are consumed downstream, not here.
  assign unused_fields = ^{inst[24:15], inst[11:7]};

  always_comb begin
    ctrl  = '0;
    legal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.ain1     = AIN1_RS1;
        ctrl.ain2     = AIN2_RS2;
        ctrl.regwrite = 1'b1;
        ctrl.map_en   = 1'b1;
        ctrl.disp     = DISP_ANY;
        if (f7 == 7'b0000000) begin
          legal      = 1'b1;
          ctrl.aluop = base_aluop(f3);
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          legal      = 1'b1;
          ctrl.aluop = ALUOP_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          legal      = 1'b1;
          ctrl.aluop = ALUOP_SRA;
        end else if (f7 == 7'b0000001) begin
          legal      = 1'b1;
          ctrl.aluop = mul_aluop(f3);
          ctrl.disp  = DISP_COMPLEX;
        end
      end
      OP_ITYPE: begin
        ctrl.ain2     = AIN2_IMM12;
        ctrl.regwrite = 1'b1;
        ctrl.map_en   = 1'b1;
        ctrl.disp     = DISP_ANY;
        ctrl.aluop    = base_aluop(f3);
        legal         = 1'b1;
        // Shift-immediates carry the shift kind in funct7, so it must be exact.
        if (f3 == 3'b001) begin
          ctrl.ain2 = AIN2_SHAMT;
          legal     = (f7 == 7'b0000000);
        end else if (f3 == 3'b101) begin
          ctrl.ain2 = AIN2_SHAMT;
          if (f7 == 7'b0100000) begin
            ctrl.aluop = ALUOP_SRA;
          end else begin
            legal = (f7 == 7'b0000000);
          end
        end
      end
      OP_LUI, OP_AUIPC: begin
        legal         = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
        ctrl.ain1     = (opcode == OP_LUI) ? AIN1_ZERO : AIN1_PC;
        ctrl.ain2     = AIN2_IMM20;
        ctrl.regwrite = 1'b1;
        ctrl.map_en   = 1'b1;
        ctrl.disp     = DISP_ANY;
      end
      OP_LOAD: begin
        legal         = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        ctrl.aluop    = ALUOP_ADD;
        ctrl.ain2     = AIN2_IMM12;
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.map_en   = 1'b1;
        ctrl.disp     = DISP_COMPLEX;
      end
      OP_STORE: begin
        legal         = (f3 <= 3'b010);
        ctrl.aluop    = ALUOP_ADD;
        ctrl.ain2     = AIN2_IMM12;
        ctrl.memwrite = 1'b1;
        ctrl.disp     = DISP_COMPLEX;
      end
      OP_BRANCH: begin
        legal       = (f3 != 3'b010) && (f3 != 3'b011);
        ctrl.aluop  = ALUOP_SUB;
        ctrl.ain2   = AIN2_RS2;
        ctrl.branch = 1'b1;
        ctrl.disp   = DISP_ANY;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
    end
    if (!lane_valid) begin
      ctrl = '0;
    end
  end
endmodule

// File: rtl/decode_group.sv
// Registered N-lane decode stage with a 2-entry skid buffer toward rename.
module decode_group
  import decode_pkg::*;
#(
  parameter int LANES = 2,
  parameter int XLEN  = 32
) (
  input logic           clk,
  input logic           rst,
  decode_group_if.slave bus
);
  lane_ctrl_t [LANES-1:0] dec_ctrl;
  lane_ctrl_t [LANES-1:0] main_ctrl_reg, skid_ctrl_reg;
  logic [LANES-1:0]       main_lv_reg, skid_lv_reg;
  logic [XLEN*LANES-1:0]  main_pc_reg, skid_pc_reg;

  skid_state_t state_reg, state_next;
  logic        in_ready_reg, out_valid_reg;
  logic        accept, drain;
  logic        load_main, load_skid, skid_to_main;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      decode_lane u_lane (
        .lane_valid (bus.in_lane_valid[gi]),
        .inst       (bus.in_inst[32*gi +: 32]),
        .ctrl       (dec_ctrl[gi])
      );

      assign bus.out_aluop[5*gi +: 5]      = main_ctrl_reg[gi].aluop;
      assign bus.out_aluin1_mux[2*gi +: 2] = main_ctrl_reg[gi].ain1;
      assign bus.out_aluin2_mux[2*gi +: 2] = main_ctrl_reg[gi].ain2;
      assign bus.out_dispatch[2*gi +: 2]   = main_ctrl_reg[gi].disp;
      assign bus.out_map_en[gi]            = main_ctrl_reg[gi].map_en;
      assign bus.out_regwrite[gi]          = main_ctrl_reg[gi].regwrite;
      assign bus.out_memread[gi]           = main_ctrl_reg[gi].memread;
      assign bus.out_memwrite[gi]          = main_ctrl_reg[gi].memwrite;
      assign bus.out_memtoreg[gi]          = main_ctrl_reg[gi].memtoreg;
      assign bus.out_branch[gi]            = main_ctrl_reg[gi].branch;
      assign bus.out_illegal[gi]           = main_ctrl_reg[gi].illegal;
    end
  endgenerate

  assign bus.in_ready       = in_ready_reg;
  assign bus.out_valid      = out_valid_reg;
  assign bus.out_lane_valid = main_lv_reg;
  assign bus.out_pc         = main_pc_reg;

  assign accept = bus.in_valid & in_ready_reg;
  assign drain  = out_valid_reg & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      in_ready_reg  <= (state_next != ST_TWO);
      out_valid_reg <= (state_next != ST_EMPTY);
    end
  end

  // Flush wins over accept and drain; the presented group is simply not loaded.
  always_comb begin
    state_next   = state_reg;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (bus.flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_next = ST_ONE;
            load_main  = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_next = ST_TWO;
            load_skid  = 1'b1;
          end else if (drain) begin
            state_next = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain) begin
            state_next   = ST_ONE;
            skid_to_main = 1'b1;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl_reg <= '0;
      main_lv_reg   <= '0;
      main_pc_reg   <= '0;
      skid_ctrl_reg <= '0;
      skid_lv_reg   <= '0;
      skid_pc_reg   <= '0;
    end else begin
      if (load_main) begin
        main_ctrl_reg <= dec_ctrl;
        main_lv_reg   <= bus.in_lane_valid;
        main_pc_reg   <= bus.in_pc;
      end else if (skid_to_main) begin
        main_ctrl_reg <= skid_ctrl_reg;
        main_lv_reg   <= skid_lv_reg;
        main_pc_reg   <= skid_pc_reg;
      end
      if (load_skid) begin
        skid_ctrl_reg <= dec_ctrl;
        skid_lv_reg   <= bus.in_lane_valid;
        skid_pc_reg   <= bus.in_pc;
      end
    end
  end
endmodule

// File: tb/tb_decode_group.sv
// Randomized and directed bench for decode_group against a queue-based model.
module tb_decode_group;
  localparam int LANES = 2;
  localparam int XLEN  = 32;
  localparam int CW    = 18;

  localparam logic [4:0] BASE_OP [8] = '{5'b00000, 5'b00010, 5'b01000, 5'b01001,
                                         5'b00011, 5'b00101, 5'b00110, 5'b00111};
  localparam logic [4:0] MUL_OP  [8] = '{5'b10110, 5'b10010, 5'b10001, 5'b10000,
                                         5'b11000, 5'b11010, 5'b11100, 5'b11110};
  localparam logic [6:0] OPS     [7] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63};

  typedef struct packed {
    logic [1:0]      lv;
    logic [63:0]     pc;
    logic [2*CW-1:0] ctl;
  } grp_t;

  logic clk = 1'b0;
  logic rst;
  grp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic acc;

  decode_group_if #(.LANES(LANES), .XLEN(XLEN)) bus ();
  decode_group #(.LANES(LANES), .XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Expected fields {aluop, ain1, ain2, disp, map, rw, mr, mw, mtr, br, illegal}.
  function automatic logic [CW-1:0] ref_decode(input logic [31:0] inst, input logic v);
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic       ok;
    logic [4:0] alu;
    logic [1:0] a1, a2, d;
    logic [5:0] fl;
    op = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25];
    ok = 1'b0; alu = '0; a1 = '0; a2 = '0; d = '0; fl = '0;
    case (op)
      7'h33: begin
        fl = 6'b110000; d = 2'b11;
        if (f7 == 7'h00) begin ok = 1'b1; alu = BASE_OP[f3]; end
        else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1'b1; alu = 5'b00001; end
        else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; alu = 5'b00100; end
        else if (f7 == 7'h01) begin ok = 1'b1; alu = MUL_OP[f3]; d = 2'b01; end
      end
      7'h13: begin
        fl = 6'b110000; d = 2'b11; a2 = 2'b10; alu = BASE_OP[f3]; ok = 1'b1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          a2 = 2'b01;
          ok = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
          if (f3 == 3'd5 && f7 == 7'h20) alu = 5'b00100;
        end
      end
      7'h37: begin ok = 1'b1; a1 = 2'b10; a2 = 2'b11; d = 2'b11; fl = 6'b110000; end
      7'h17: begin ok = 1'b1; a1 = 2'b01; a2 = 2'b11; d = 2'b11; fl = 6'b110000; end
      7'h03: begin ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; a2 = 2'b10; d = 2'b01; fl = 6'b111010; end
      7'h23: begin ok = (f3 <= 3'd2); a2 = 2'b10; d = 2'b01; fl = 6'b000100; end
      7'h63: begin ok = !(f3 == 3'd2 || f3 == 3'd3); alu = 5'b00001; d = 2'b11; fl = 6'b000001; end
      default: ok = 1'b0;
    endcase
    if (!v) return '0;
    if (!ok) return {{(CW-1){1'b0}}, 1'b1};
    return {alu, a1, a2, d, fl, 1'b0};
  endfunction

  function automatic logic [CW-1:0] obs_ctl(input int k);
    return {bus.out_aluop[5*k +: 5], bus.out_aluin1_mux[2*k +: 2], bus.out_aluin2_mux[2*k +: 2],
            bus.out_dispatch[2*k +: 2], bus.out_map_en[k], bus.out_regwrite[k], bus.out_memread[k],
            bus.out_memwrite[k], bus.out_memtoreg[k], bus.out_branch[k], bus.out_illegal[k]};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    if ($urandom_range(0, 7) != 0) r[6:0] = OPS[$urandom_range(0, 6)];
    return r;
  endfunction

  task automatic check_outputs();
    check("in_ready", {63'd0, bus.in_ready}, {63'd0, q.size() < 2});
    check("out_valid", {63'd0, bus.out_valid}, {63'd0, q.size() != 0});
    if (q.size() != 0) begin
      check("lane_valid", {62'd0, bus.out_lane_valid}, {62'd0, q[0].lv});
      check("pc", bus.out_pc, q[0].pc);
      for (int k = 0; k < LANES; k++)
        check($sformatf("ctl_lane%0d", k), {46'd0, obs_ctl(k)}, {46'd0, q[0].ctl[k*CW +: CW]});
    end
  endtask

  // One clock: drive inputs, update the model at the edge, check at negedge.
  task automatic cycle(input logic fl, input logic iv, input logic [1:0] lv,
                       input logic [31:0] i0, input logic [31:0] i1,
                       input logic [63:0] pcs, input logic ordy, output logic accepted);
    grp_t g;
    int   sz;
    bus.flush = fl; bus.in_valid = iv; bus.in_lane_valid = lv;
    bus.in_inst = {i1, i0}; bus.in_pc = pcs; bus.out_ready = ordy;
    g.lv = lv; g.pc = pcs; g.ctl = {ref_decode(i1, lv[1]), ref_decode(i0, lv[0])};
    @(posedge clk);
    sz = q.size();
    accepted = !fl && iv && (sz < 2);
    if (fl) begin
      q.delete();
    end else begin
      if (sz > 0 && ordy) void'(q.pop_front());
      if (iv && sz < 2) q.push_back(g);
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic [31:0] a, b;
    logic [63:0] pcs;
    int          got, cyc;

    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_lane_valid = '0;
    bus.in_inst = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    #7;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_aluop", {54'd0, bus.out_aluop}, 64'd0);
    check("rst_pc", bus.out_pc, 64'd0);
    check("rst_lane_valid", {62'd0, bus.out_lane_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("txn add/sub");
    cycle(1'b0, 1'b1, 2'b11, 32'h002081B3, 32'h402081B3, 64'h00001004_00001000, 1'b1, acc);
    check("addsub_aluop", {54'd0, bus.out_aluop}, {54'd0, 10'b00001_00000});
    check("addsub_regwrite", {62'd0, bus.out_regwrite}, 64'd3);

    $display("txn mul/srai");
    cycle(1'b0, 1'b1, 2'b11, 32'h022081B3, 32'h4030D093, 64'h0000100C_00001008, 1'b1, acc);
    check("mulsrai_aluop", {54'd0, bus.out_aluop}, {54'd0, 10'b00100_10110});
    check("mulsrai_disp", {60'd0, bus.out_dispatch}, {60'd0, 4'b11_01});
    check("mulsrai_mux2", {60'd0, bus.out_aluin2_mux}, {60'd0, 4'b01_00});

    $display("txn lw/illegal");
    cycle(1'b0, 1'b1, 2'b11, 32'h0000A183, 32'hFFFFFFFF, 64'h00001014_00001010, 1'b1, acc);
    check("lwill_illegal", {62'd0, bus.out_illegal}, 64'd2);
    check("lwill_memread", {62'd0, bus.out_memread}, 64'd1);
    check("lwill_ctl1_zero", {46'd0, obs_ctl(1)}, 64'd1);

    // Five groups with in_valid held; rename stalls for cycles 1..3.
    got = 0;
    for (cyc = 0; cyc < 20 && got < 5; cyc++) begin
      $display("txn backpressure cyc=%0d group=%0d", cyc, got);
      pcs = {32'h2004 + 32'(got) * 8, 32'h2000 + 32'(got) * 8};
      cycle(1'b0, 1'b1, 2'b11, 32'h00000013 | (32'(got) << 7), 32'h00100093,
            pcs, !(cyc >= 1 && cyc <= 3), acc);
      if (acc) got++;
    end
    check("bp_all_accepted", 64'(got), 64'd5);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 64'd0, 1'b1, acc);

    // Fill both entries, then flush while a new group is presented.
    for (int i = 0; i < 2; i++)
      cycle(1'b0, 1'b1, 2'b11, rand_inst(), rand_inst(), {$urandom, $urandom}, 1'b0, acc);
    $display("txn flush");
    cycle(1'b1, 1'b1, 2'b11, 32'h002081B3, 32'h002081B3, 64'hDEAD0004_DEAD0000, 1'b0, acc);
    check("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 64'd0, 1'b1, acc);

    // Asynchronous reset between edges.
    for (int i = 0; i < 2; i++)
      cycle(1'b0, 1'b1, 2'b11, rand_inst(), rand_inst(), {$urandom, $urandom}, 1'b0, acc);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    $display("txn async reset");
    check("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("arst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("arst_lane_valid", {62'd0, bus.out_lane_valid}, 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      a = rand_inst(); b = rand_inst();
      $display("txn rand %0d inst %h %h", i, a, b);
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            a, b, {$urandom, $urandom}, $urandom_range(0, 4) < 3, acc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
